// File: rtl/seq_dsp_alu_if.sv
// Purpose: handshake bundle between decode/ALU-control, the ALU and writeback.
// Latency: none; this is wiring only.
// Backpressure: carries in_valid/in_ready on the request side and out_valid/out_ready on the result side.
// Ports: in_valid/in_ready, op, a, b (request); out_valid/out_ready, result, zero (response).
interface seq_dsp_alu_if #(
   parameter int WIDTH = 32
);
   logic             in_valid;
   logic             in_ready;
   logic [3:0]       op;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] result;
   logic             zero;

   // master: the side that issues ops and consumes results
   modport master (
      output in_valid, op, a, b, out_ready,
      input  in_ready, out_valid, result, zero
   );

   // slave: the ALU itself
   modport slave (
      input  in_valid, op, a, b, out_ready,
      output in_ready, out_valid, result, zero
   );
endinterface

// File: rtl/seq_dsp_alu.sv
// Purpose: RV32I integer ALU plus RV32M multiplies via an iterative radix-2 shift-add engine.
// Latency: integer ops 1 edge (accepting edge); multiplies WIDTH+1 edges after the accepting edge.
// Backpressure: result registered and held while out_valid && !out_ready; in_ready low while busy or held.
// Ports: clk, rst (async, active-high); bus (slave modport) carries in_valid/in_ready/op/a/b and
//        out_valid/out_ready/result/zero.
module seq_dsp_alu #(
   parameter int WIDTH = 32,
   parameter int SHW   = 5
) (
   input  logic          clk,
   input  logic          rst,
   seq_dsp_alu_if.slave  bus
);

   localparam logic [3:0] OP_ADD    = 4'd0;
   localparam logic [3:0] OP_SUB    = 4'd1;
   localparam logic [3:0] OP_AND    = 4'd2;
   localparam logic [3:0] OP_OR     = 4'd3;
   localparam logic [3:0] OP_XOR    = 4'd4;
   localparam logic [3:0] OP_SLT    = 4'd5;
   localparam logic [3:0] OP_SLTU   = 4'd6;
   localparam logic [3:0] OP_SLL    = 4'd7;
   localparam logic [3:0] OP_SRL    = 4'd8;
   localparam logic [3:0] OP_SRA    = 4'd9;
   localparam logic [3:0] OP_MUL    = 4'd10;
   localparam logic [3:0] OP_MULH   = 4'd11;
   localparam logic [3:0] OP_MULHSU = 4'd12;
   localparam logic [3:0] OP_MULHU  = 4'd13;
   localparam logic [3:0] OP_EQ     = 4'd14;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_MUL  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic             out_valid_q, out_valid_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic [WIDTH-1:0] mcand_q, mcand_d;   // |a|
   logic [WIDTH-1:0] lo_q, lo_d;         // starts as |b|, fills with low product bits
   logic [WIDTH-1:0] hi_q, hi_d;         // running high half of the product
   logic             neg_q, neg_d;       // product sign
   logic             hisel_q, hisel_d;   // return high half (MULH*) vs low half (MUL)
   logic [SHW-1:0]   cnt_q, cnt_d;

   logic             in_ready;
   logic             accept;
   logic             is_mul;
   logic [SHW-1:0]   shamt;
   logic [WIDTH-1:0] alu_res;
   logic             a_neg, b_neg;
   logic [WIDTH:0]   step_sum;
   logic [2*WIDTH-1:0] prod_mag, prod_fix;

   // rst gates in_ready so nothing is accepted while the block is held in reset
   assign in_ready = !rst && (state_q == S_IDLE) && (!out_valid_q || bus.out_ready);
   assign accept   = bus.in_valid && in_ready;
   assign is_mul   = (bus.op >= OP_MUL) && (bus.op <= OP_MULHU);
   assign shamt    = bus.b[SHW-1:0];

   always_comb begin
      alu_res = '0;
      unique case (bus.op)
         OP_ADD:  alu_res = bus.a + bus.b;
         OP_SUB:  alu_res = bus.a - bus.b;
         OP_AND:  alu_res = bus.a & bus.b;
         OP_OR:   alu_res = bus.a | bus.b;
         OP_XOR:  alu_res = bus.a ^ bus.b;
         OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(bus.a) < $signed(bus.b))};
         OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (bus.a < bus.b)};
         OP_SLL:  alu_res = bus.a << shamt;
         OP_SRL:  alu_res = bus.a >> shamt;
         OP_SRA:  alu_res = $unsigned($signed(bus.a) >>> shamt);
         OP_EQ:   alu_res = {{(WIDTH-1){1'b0}}, (bus.a == bus.b)};
         default: alu_res = '0;   // multiplies are produced by the engine; 15 is reserved
      endcase
   end

   // Operand signedness: MUL only needs the low half, which is sign-agnostic, so it runs unsigned.
   assign a_neg = ((bus.op == OP_MULH) || (bus.op == OP_MULHSU)) && bus.a[WIDTH-1];
   assign b_neg = (bus.op == OP_MULH) && bus.b[WIDTH-1];

   // One shift-add step: add |a| into the high half when the current multiplier bit is set,
   // then shift the {carry, hi, lo} chain right by one.
   assign step_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, mcand_q} : {(WIDTH+1){1'b0}});

   assign prod_mag = {hi_q, lo_q};
   assign prod_fix = neg_q ? (~prod_mag + 1'b1) : prod_mag;

   always_comb begin
      state_d     = state_q;
      out_valid_d = out_valid_q && !bus.out_ready;
      result_d    = result_q;
      mcand_d     = mcand_q;
      lo_d        = lo_q;
      hi_d        = hi_q;
      neg_d       = neg_q;
      hisel_d     = hisel_q;
      cnt_d       = cnt_q;
      unique case (state_q)
         S_IDLE: begin
            if (accept) begin
               if (is_mul) begin
                  state_d = S_MUL;
                  mcand_d = a_neg ? (~bus.a + 1'b1) : bus.a;
                  lo_d    = b_neg ? (~bus.b + 1'b1) : bus.b;
                  hi_d    = '0;
                  neg_d   = a_neg ^ b_neg;
                  hisel_d = (bus.op != OP_MUL);
                  cnt_d   = '0;
               end else begin
                  result_d    = alu_res;
                  out_valid_d = 1'b1;
               end
            end
         end
         S_MUL: begin
            hi_d  = step_sum[WIDTH:1];
            lo_d  = {step_sum[0], lo_q[WIDTH-1:1]};
            cnt_d = cnt_q + SHW'(1);
            if (cnt_q == SHW'(WIDTH-1)) begin
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            result_d    = hisel_q ? prod_fix[2*WIDTH-1:WIDTH] : prod_fix[WIDTH-1:0];
            out_valid_d = 1'b1;
            state_d     = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         out_valid_q <= 1'b0;
         result_q    <= '0;
         mcand_q     <= '0;
         lo_q        <= '0;
         hi_q        <= '0;
         neg_q       <= 1'b0;
         hisel_q     <= 1'b0;
         cnt_q       <= '0;
      end else begin
         state_q     <= state_d;
         out_valid_q <= out_valid_d;
         result_q    <= result_d;
         mcand_q     <= mcand_d;
         lo_q        <= lo_d;
         hi_q        <= hi_d;
         neg_q       <= neg_d;
         hisel_q     <= hisel_d;
         cnt_q       <= cnt_d;
      end
   end

   assign bus.in_ready  = in_ready;
   assign bus.out_valid = out_valid_q;
   assign bus.result    = result_q;
   assign bus.zero      = (result_q == '0);

endmodule

// File: tb/tb_seq_dsp_alu.sv
// Purpose: directed scoreboard bench for seq_dsp_alu (integer ops, multiplies, backpressure, reset abort).
// Latency: expected latency is stored per op as edges after the accepting edge (0 integer, 33 multiply).
// Backpressure: the monitor only pops on out_valid && out_ready; the driver holds in_valid until accepted.
module tb_seq_dsp_alu;

   localparam logic [3:0] OP_ADD    = 4'd0;
   localparam logic [3:0] OP_SUB    = 4'd1;
   localparam logic [3:0] OP_AND    = 4'd2;
   localparam logic [3:0] OP_OR     = 4'd3;
   localparam logic [3:0] OP_XOR    = 4'd4;
   localparam logic [3:0] OP_SLT    = 4'd5;
   localparam logic [3:0] OP_SLTU   = 4'd6;
   localparam logic [3:0] OP_SLL    = 4'd7;
   localparam logic [3:0] OP_SRL    = 4'd8;
   localparam logic [3:0] OP_SRA    = 4'd9;
   localparam logic [3:0] OP_MUL    = 4'd10;
   localparam logic [3:0] OP_MULH   = 4'd11;
   localparam logic [3:0] OP_MULHSU = 4'd12;
   localparam logic [3:0] OP_MULHU  = 4'd13;
   localparam logic [3:0] OP_EQ     = 4'd14;
   localparam logic [3:0] OP_RSVD   = 4'd15;

   logic clk;
   logic rst;
   int   cyc;
   int   checks;
   int   errors;

   typedef struct {
      logic [31:0] res;
      int          lat;
      int          acc;
   } exp_t;

   exp_t q[$];

   seq_dsp_alu_if #(.WIDTH(32)) bus ();

   seq_dsp_alu #(.WIDTH(32), .SHW(5)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   // Drive one op, hold it until accepted, then push the expected response.
   // Called in the phase just after a rising edge; returns 1 time unit after the accepting edge.
   task automatic send(input logic [3:0] op_v, input logic [31:0] a_v, input logic [31:0] b_v,
                       input logic [31:0] exp_res, input int lat, input bit track);
      bit rdy;
      bit done;
      int busy_bad;
      done = 1'b0;
      bus.in_valid = 1'b1;
      bus.op = op_v;
      bus.a = a_v;
      bus.b = b_v;
      for (int k = 0; k < 100 && !done; k++) begin
         @(negedge clk);
         rdy = bus.in_ready;
         @(posedge clk);
         #1;
         if (rdy) done = 1'b1;
      end
      bus.in_valid = 1'b0;
      checks++;
      if (!done) begin
         errors++;
         $display("FAIL accept op=%0d: in_ready never 1 within 100 cycles, required 1", op_v);
         return;
      end
      if (track) q.push_back('{exp_res, lat, cyc});
      if (lat > 0) begin
         busy_bad = 0;
         for (int i = 0; i < lat; i++) begin
            @(negedge clk);
            if (bus.in_ready) busy_bad++;
         end
         checks++;
         if (busy_bad != 0) begin
            errors++;
            $display("FAIL busy_in_ready op=%0d: in_ready high in %0d of %0d busy cycles, required 0",
                     op_v, busy_bad, lat);
         end
      end
   endtask

   // Monitor: records when a result first appears, compares on the consuming edge.
   bit seen;
   int first_cyc;
   initial seen = 1'b0;
   initial first_cyc = 0;

   always @(negedge clk) begin
      exp_t e;
      if (rst) begin
         seen = 1'b0;
      end else begin
         if (bus.out_valid && !seen) begin
            seen = 1'b1;
            first_cyc = cyc;
         end
         if (bus.out_valid && bus.out_ready) begin
            if (q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_result: got 0x%08h with nothing outstanding, required no out_valid",
                        bus.result);
            end else begin
               e = q.pop_front();
               checks++;
               if (bus.result !== e.res) begin
                  errors++;
                  $display("FAIL result: got 0x%08h, expected 0x%08h", bus.result, e.res);
               end
               checks++;
               if (bus.zero !== (e.res == 32'h0)) begin
                  errors++;
                  $display("FAIL zero: got %0b, expected %0b (result 0x%08h)", bus.zero, (e.res == 32'h0), e.res);
               end
               checks++;
               if ((first_cyc - e.acc) != e.lat) begin
                  errors++;
                  $display("FAIL latency: got %0d edges after accept, expected %0d (result 0x%08h)",
                           first_cyc - e.acc, e.lat, e.res);
               end
            end
            seen = 1'b0;
         end
      end
   end

   initial begin
      int vbad;
      checks = 0;
      errors = 0;
      rst = 1'b1;
      bus.in_valid = 1'b0;
      bus.op = 4'd0;
      bus.a = 32'h0;
      bus.b = 32'h0;
      bus.out_ready = 1'b1;

      // Reset state
      repeat (2) @(negedge clk);
      chk("rst_out_valid", {31'h0, bus.out_valid}, 32'h0);
      chk("rst_result", bus.result, 32'h0);
      chk("rst_zero", {31'h0, bus.zero}, 32'h1);
      chk("rst_in_ready", {31'h0, bus.in_ready}, 32'h0);
      rst = 1'b0;
      @(posedge clk);
      #1;

      // Integer ops
      send(OP_AND,  32'h0000000F, 32'h00000055, 32'h00000005, 0, 1'b1);
      send(OP_SUB,  32'd10000,    32'd111,      32'd9889,     0, 1'b1);
      send(OP_SUB,  32'h00000000, 32'h00000001, 32'hFFFFFFFF, 0, 1'b1);
      send(OP_EQ,   32'h00000007, 32'h00000007, 32'h00000001, 0, 1'b1);
      send(OP_SLTU, 32'h00000001, 32'hFFFFFFFF, 32'h00000001, 0, 1'b1);
      send(OP_SLT,  32'hFFFFFFFF, 32'h00000001, 32'h00000001, 0, 1'b1);
      send(OP_SRA,  32'h80000000, 32'h00000021, 32'hC0000000, 0, 1'b1);
      send(OP_SRL,  32'h80000000, 32'h00000021, 32'h40000000, 0, 1'b1);
      send(OP_SLL,  32'h00000002, 32'h00000002, 32'h00000008, 0, 1'b1);
      send(OP_AND,  32'h000000F0, 32'h0000000F, 32'h00000000, 0, 1'b1);
      send(OP_XOR,  32'h0000FF00, 32'h00000FF0, 32'h0000F0F0, 0, 1'b1);
      send(OP_OR,   32'h12000000, 32'h00000034, 32'h12000034, 0, 1'b1);
      send(OP_RSVD, 32'h00000005, 32'h00000005, 32'h00000000, 0, 1'b1);

      // Multiplies
      send(OP_MUL,    32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFEB, 33, 1'b1);
      send(OP_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33, 1'b1);
      send(OP_MULH,   32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 33, 1'b1);
      send(OP_MULH,   32'h80000000, 32'h80000000, 32'h40000000, 33, 1'b1);
      send(OP_MULHSU, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, 33, 1'b1);

      for (int k = 0; k < 100 && q.size() != 0; k++) @(posedge clk);
      #1;

      // Backpressure: hold 1+2 for 5 cycles, then consume it while 4+4 is accepted on the same edge
      bus.out_ready = 1'b0;
      send(OP_ADD, 32'd1, 32'd2, 32'd3, 0, 1'b1);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("hold_out_valid", {31'h0, bus.out_valid}, 32'h1);
         chk("hold_result", bus.result, 32'd3);
         chk("hold_in_ready", {31'h0, bus.in_ready}, 32'h0);
      end
      @(posedge clk);
      #1;
      bus.out_ready = 1'b1;
      send(OP_ADD, 32'd4, 32'd4, 32'd8, 0, 1'b1);

      for (int k = 0; k < 100 && q.size() != 0; k++) @(posedge clk);
      #1;

      // Reset in the middle of a multiply (after 10 iterations): aborted, no result
      send(OP_MUL, 32'd3, 32'd5, 32'd15, 0, 1'b0);
      repeat (10) @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      chk("abort_out_valid", {31'h0, bus.out_valid}, 32'h0);
      chk("abort_result", bus.result, 32'h0);
      chk("abort_zero", {31'h0, bus.zero}, 32'h1);
      chk("abort_in_ready", {31'h0, bus.in_ready}, 32'h0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      vbad = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (bus.out_valid) vbad++;
      end
      chk("abort_no_pulse", vbad, 32'd0);
      chk("abort_idle_ready", {31'h0, bus.in_ready}, 32'h1);
      @(posedge clk);
      #1;
      send(OP_ADD, 32'd5, 32'd5, 32'd10, 0, 1'b1);

      for (int k = 0; k < 100 && q.size() != 0; k++) @(posedge clk);
      checks++;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d results outstanding, required 0", q.size());
      end
      repeat (2) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
